// File: rtl/pram_access_arbiter_if.sv
// Bus bundle between the program-RAM arbiter, its requesters (loader, fetch, data port)
// and the single-port pram macro. The arbiter takes the slave side.
interface pram_access_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              ld_from_ext;
    logic              ld_we;
    logic [15:0]       ld_addr;
    logic [DATA_W-1:0] ld_wdata;

    logic              if_req;
    logic [15:0]       if_addr;
    logic              if_gnt;
    logic              if_rvalid;

    logic              dm_req;
    logic              dm_we;
    logic [3:0]        dm_be;
    logic [15:0]       dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;

    logic [DATA_W-1:0] rdata;
    logic              err;

    logic              pram_en;
    logic [3:0]        pram_we;
    logic [ADDR_W-1:0] pram_addr;
    logic [DATA_W-1:0] pram_wdata;
    logic [DATA_W-1:0] pram_rdata;

    logic              busy_load;

    // System side: requesters plus the pram macro's read data.
    modport master (
        output ld_from_ext, ld_we, ld_addr, ld_wdata,
        output if_req, if_addr,
        output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        output pram_rdata,
        input  if_gnt, if_rvalid, dm_gnt, dm_rvalid, rdata, err,
        input  pram_en, pram_we, pram_addr, pram_wdata, busy_load
    );

    modport slave (
        input  ld_from_ext, ld_we, ld_addr, ld_wdata,
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        input  pram_rdata,
        output if_gnt, if_rvalid, dm_gnt, dm_rvalid, rdata, err,
        output pram_en, pram_we, pram_addr, pram_wdata, busy_load
    );
endinterface

// File: rtl/pram_access_arbiter.sv
// Program-RAM access arbiter: exclusive loader access during init, then per-cycle
// fetch/data arbitration. Define PRAM_ARB_RR_EN for round-robin instead of fetch priority.
module pram_access_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic                 i_clk,
    input  logic                 i_a_reset_l,
    pram_access_arbiter_if.slave bus
);
    typedef enum logic [1:0] {ST_LOAD, ST_SWITCH, ST_RUN} state_t;
    typedef enum logic {REQ_IF = 1'b0, REQ_DM = 1'b1} req_t;

    state_t state_reg, state_next;
    logic   rd_valid_reg, rd_valid_next;
    req_t   rd_tag_reg, rd_tag_next;
    logic   rd_err_reg, rd_err_next;
`ifdef PRAM_ARB_RR_EN
    req_t   rr_last_reg, rr_last_next;
`endif

    logic              if_gnt;
    logic              dm_gnt;
    logic              dm_wins;
    logic              pram_en;
    logic [3:0]        pram_we;
    logic [ADDR_W-1:0] pram_addr;
    logic [DATA_W-1:0] pram_wdata;

    function automatic logic in_range(input logic [15:0] addr);
        return (addr >> (ADDR_W + 2)) == 16'd0;
    endfunction

    function automatic logic [ADDR_W-1:0] word_addr(input logic [15:0] addr);
        return addr[ADDR_W+1:2];
    endfunction

    // Only consulted when the data port actually requests.
    always_comb begin
`ifdef PRAM_ARB_RR_EN
        dm_wins = bus.dm_req && (!bus.if_req || rr_last_reg == REQ_IF);
`else
        dm_wins = bus.dm_req && !bus.if_req;
`endif
    end

    always_comb begin
        state_next    = state_reg;
        rd_valid_next = 1'b0;
        rd_tag_next   = REQ_IF;
        rd_err_next   = 1'b0;
`ifdef PRAM_ARB_RR_EN
        rr_last_next  = rr_last_reg;
`endif
        if_gnt     = 1'b0;
        dm_gnt     = 1'b0;
        pram_en    = 1'b0;
        pram_we    = 4'h0;
        pram_addr  = '0;
        pram_wdata = '0;

        case (state_reg)
            ST_LOAD: begin
                if (bus.ld_we && in_range(bus.ld_addr)) begin
                    pram_en    = 1'b1;
                    pram_we    = 4'hF;
                    pram_addr  = word_addr(bus.ld_addr);
                    pram_wdata = bus.ld_wdata;
                end
                if (!bus.ld_from_ext) state_next = ST_SWITCH;
            end
            ST_SWITCH: begin
                state_next = bus.ld_from_ext ? ST_LOAD : ST_RUN;
            end
            ST_RUN: begin
                if (bus.ld_from_ext) begin
                    state_next = ST_LOAD;
                end else if (dm_wins) begin
                    dm_gnt = 1'b1;
`ifdef PRAM_ARB_RR_EN
                    rr_last_next = REQ_DM;
`endif
                    if (bus.dm_we) begin
                        // An all-zero byte mask is a no-op, so the macro is left idle.
                        if (in_range(bus.dm_addr) && bus.dm_be != 4'h0) begin
                            pram_en    = 1'b1;
                            pram_we    = bus.dm_be;
                            pram_addr  = word_addr(bus.dm_addr);
                            pram_wdata = bus.dm_wdata;
                        end
                    end else begin
                        rd_valid_next = 1'b1;
                        rd_tag_next   = REQ_DM;
                        rd_err_next   = !in_range(bus.dm_addr);
                        if (in_range(bus.dm_addr)) begin
                            pram_en   = 1'b1;
                            pram_addr = word_addr(bus.dm_addr);
                        end
                    end
                end else if (bus.if_req) begin
                    if_gnt = 1'b1;
`ifdef PRAM_ARB_RR_EN
                    rr_last_next = REQ_IF;
`endif
                    rd_valid_next = 1'b1;
                    rd_tag_next   = REQ_IF;
                    rd_err_next   = !in_range(bus.if_addr);
                    if (in_range(bus.if_addr)) begin
                        pram_en   = 1'b1;
                        pram_addr = word_addr(bus.if_addr);
                    end
                end
            end
            default: state_next = ST_LOAD;
        endcase
    end

    // The read tag is captured unconditionally so a response survives leaving RUN.
    always_ff @(posedge i_clk or negedge i_a_reset_l) begin
        if (!i_a_reset_l) begin
            state_reg    <= ST_LOAD;
            rd_valid_reg <= 1'b0;
            rd_tag_reg   <= REQ_IF;
            rd_err_reg   <= 1'b0;
`ifdef PRAM_ARB_RR_EN
            rr_last_reg  <= REQ_DM;
`endif
        end else begin
            state_reg    <= state_next;
            rd_valid_reg <= rd_valid_next;
            rd_tag_reg   <= rd_tag_next;
            rd_err_reg   <= rd_err_next;
`ifdef PRAM_ARB_RR_EN
            rr_last_reg  <= rr_last_next;
`endif
        end
    end

    assign bus.if_gnt     = if_gnt;
    assign bus.dm_gnt     = dm_gnt;
    assign bus.pram_en    = pram_en;
    assign bus.pram_we    = pram_we;
    assign bus.pram_addr  = pram_addr;
    assign bus.pram_wdata = pram_wdata;

    assign bus.if_rvalid = rd_valid_reg && (rd_tag_reg == REQ_IF);
    assign bus.dm_rvalid = rd_valid_reg && (rd_tag_reg == REQ_DM);
    assign bus.err       = rd_valid_reg && rd_err_reg;
    assign bus.rdata     = (rd_valid_reg && !rd_err_reg) ? bus.pram_rdata : '0;
    assign bus.busy_load = (state_reg != ST_RUN);
endmodule

// File: tb/tb_pram_access_arbiter.sv
// Bench for pram_access_arbiter: directed scenarios then random traffic, compared against a
// behavioural model holding the expected RAM contents and the outstanding read.
module tb_pram_access_arbiter;
    localparam int AW = 12;
    localparam int DW = 32;
`ifdef PRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk;
    logic rst_l;
    int   n_cmp;
    int   n_bad;

    pram_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    pram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk       (clk),
        .i_a_reset_l (rst_l),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM macro with one-cycle registered read.
    logic [31:0] pmem [0:4095];
    logic [31:0] prd;
    always @(posedge clk) begin
        if (bus.pram_en) begin
            for (int b = 0; b < 4; b++)
                if (bus.pram_we[b]) pmem[bus.pram_addr][8*b +: 8] <= bus.pram_wdata[8*b +: 8];
            if (bus.pram_we == 4'h0) prd <= pmem[bus.pram_addr];
        end
    end
    assign bus.pram_rdata = prd;

    // Reference model state.
    typedef enum {M_LOAD, M_SWITCH, M_RUN} mode_t;
    mode_t       m_mode;
    bit          m_last_dm;
    logic [31:0] gold [0:4095];
    bit          p_valid, p_dm, p_err;
    logic [31:0] p_data;
    bit          last_ifg, last_dmg, obs_ifg, obs_dmg;
    logic [31:0] ld_data [0:2];

    task automatic model_reset();
        m_mode = M_LOAD; m_last_dm = 1'b1; p_valid = 1'b0; p_dm = 1'b0; p_err = 1'b0; p_data = '0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rand_addr();
        logic [15:0] a;
        case ($urandom_range(0, 5))
            0:       a = 16'h3FFC;
            1:       a = 16'h4000 + 16'($urandom_range(0, 16'hBFFF));
            default: a = 16'($urandom_range(0, 15) * 4);
        endcase
        return a | 16'($urandom_range(0, 3));
    endfunction

    // Inputs are driven at the falling edge; one call = one clock cycle.
    task automatic step(input string tag);
        logic e_ifg, e_dmg, e_en, dm_first, ok, n_rd, n_dm, n_err;
        logic [3:0]  e_we;
        logic [11:0] e_addr;
        logic [31:0] e_wd, n_data;
        logic [15:0] a;
        #1;
        e_ifg = 0; e_dmg = 0; e_en = 0; e_we = 0; e_addr = 0; e_wd = 0;
        n_rd = 0; n_dm = 0; n_err = 0; n_data = 0;
        if (m_mode == M_LOAD) begin
            if (bus.ld_we && bus.ld_addr < 16'h4000) begin
                e_en = 1; e_we = 4'hF; e_addr = 12'(bus.ld_addr / 4); e_wd = bus.ld_wdata;
            end
        end else if (m_mode == M_RUN && !bus.ld_from_ext && (bus.if_req || bus.dm_req)) begin
            if (bus.if_req && bus.dm_req) dm_first = RR && !m_last_dm;
            else dm_first = bus.dm_req;
            e_dmg = dm_first; e_ifg = !dm_first;
            a  = dm_first ? bus.dm_addr : bus.if_addr;
            ok = a < 16'h4000;
            if (dm_first && bus.dm_we) begin
                if (ok && bus.dm_be != 0) begin
                    e_en = 1; e_we = bus.dm_be; e_addr = 12'(a / 4); e_wd = bus.dm_wdata;
                end
            end else begin
                n_rd = 1; n_dm = dm_first; n_err = !ok;
                n_data = ok ? gold[a / 4] : 32'h0;
                if (ok) begin e_en = 1; e_addr = 12'(a / 4); end
            end
        end
        obs_ifg = bus.if_gnt; obs_dmg = bus.dm_gnt;
        chk({tag, ".if_gnt"},    32'(bus.if_gnt),    32'(e_ifg));
        chk({tag, ".dm_gnt"},    32'(bus.dm_gnt),    32'(e_dmg));
        chk({tag, ".pram_en"},   32'(bus.pram_en),   32'(e_en));
        chk({tag, ".pram_we"},   32'(bus.pram_we),   32'(e_we));
        if (e_en) chk({tag, ".pram_addr"}, 32'(bus.pram_addr), 32'(e_addr));
        if (e_we != 0) chk({tag, ".pram_wdata"}, bus.pram_wdata, e_wd);
        chk({tag, ".if_rvalid"}, 32'(bus.if_rvalid), 32'(p_valid && !p_dm));
        chk({tag, ".dm_rvalid"}, 32'(bus.dm_rvalid), 32'(p_valid && p_dm));
        chk({tag, ".err"},       32'(bus.err),       32'(p_valid && p_err));
        chk({tag, ".rdata"},     bus.rdata,          p_valid ? p_data : 32'h0);
        chk({tag, ".busy_load"}, 32'(bus.busy_load), 32'(m_mode != M_RUN));
        @(posedge clk);
        for (int b = 0; b < 4; b++) if (e_we[b]) gold[e_addr][8*b +: 8] = e_wd[8*b +: 8];
        p_valid = n_rd; p_dm = n_dm; p_err = n_err; p_data = n_data;
        if (e_ifg || e_dmg) m_last_dm = e_dmg;
        case (m_mode)
            M_LOAD:   if (!bus.ld_from_ext) m_mode = M_SWITCH;
            M_SWITCH: m_mode = bus.ld_from_ext ? M_LOAD : M_RUN;
            default:  if (bus.ld_from_ext) m_mode = M_LOAD;
        endcase
        last_ifg = e_ifg; last_dmg = e_dmg;
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] seq;
        bit         if_hold, dm_hold;
        int         ld_cnt;
        n_cmp = 0; n_bad = 0;
        bus.ld_from_ext = 1; bus.ld_we = 0; bus.ld_addr = 0; bus.ld_wdata = 0;
        bus.if_req = 0; bus.if_addr = 0;
        bus.dm_req = 0; bus.dm_we = 0; bus.dm_be = 0; bus.dm_addr = 0; bus.dm_wdata = 0;
        rst_l = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst.busy_load", 32'(bus.busy_load), 32'h1);
        chk("rst.rvalid", 32'({bus.if_rvalid, bus.dm_rvalid}), 32'h0);
        rst_l = 1;
        step("reset");

        // 1: three loader writes, then fill the rest of the window used later.
        for (int k = 0; k < 3; k++) begin
            ld_data[k] = $urandom;
            bus.ld_we = 1; bus.ld_addr = 16'(k * 4); bus.ld_wdata = ld_data[k];
            step("t1.load");
        end
        for (int w = 3; w < 17; w++) begin
            bus.ld_addr = (w == 16) ? 16'h3FFC : 16'(w * 4); bus.ld_wdata = $urandom;
            step("t1.fill");
        end
        bus.ld_we = 0;

        // 2: leave LOAD with a fetch already waiting.
        bus.ld_from_ext = 0; bus.if_req = 1; bus.if_addr = 16'h0004;
        step("t2.load_exit");
        step("t2.switch");
        chk("t2.no_gnt_in_switch", 32'(obs_ifg), 32'h0);
        step("t2.grant");
        chk("t2.if_gnt", 32'(obs_ifg), 32'h1);
        bus.if_req = 0;
        #1 chk("t2.rdata", bus.rdata, ld_data[1]);
        step("t2.rvalid");

        // 3: both requesters held for four cycles (last grant was fetch).
        bus.if_req = 1; bus.if_addr = 16'h0008;
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 16'h000C;
        for (int k = 0; k < 4; k++) begin
            step("t3.both");
            seq[k] = obs_dmg;
        end
        chk("t3.grant_seq", 32'(seq), RR ? 32'h5 : 32'h0);
        bus.if_req = 0; bus.dm_req = 0;
        step("t3.drain");

        // 4: out-of-range data read.
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 16'h4000;
        step("t4.oor_read");
        bus.dm_req = 0;
        #1 chk("t4.err", 32'(bus.err), 32'h1);
        step("t4.rvalid");

        // 5: partial write, then read the merged word back.
        bus.dm_req = 1; bus.dm_we = 1; bus.dm_be = 4'b0011; bus.dm_addr = 16'h0010; bus.dm_wdata = $urandom;
        step("t5.write");
        bus.dm_we = 0;
        step("t5.readback");
        bus.dm_req = 0;
        step("t5.rvalid");

        // 6: loader reclaims the RAM right after a fetch grant.
        bus.if_req = 1; bus.if_addr = 16'h0000;
        step("t6.grant");
        bus.ld_from_ext = 1;
        step("t6.rvalid_on_exit");
        step("t6.load");
        chk("t6.no_gnt", 32'(obs_ifg), 32'h0);
        bus.ld_from_ext = 0; bus.if_req = 0;
        repeat (3) step("t6.back_to_run");

        // Random traffic with occasional loader phases.
        if_hold = 0; dm_hold = 0; ld_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            if (!if_hold) begin bus.if_req = $urandom_range(0, 2) != 0; bus.if_addr = rand_addr(); end
            if (!dm_hold) begin
                bus.dm_req = $urandom_range(0, 2) != 0; bus.dm_we = 1'($urandom);
                bus.dm_be = 4'($urandom); bus.dm_addr = rand_addr(); bus.dm_wdata = $urandom;
            end
            if (ld_cnt > 0) begin
                bus.ld_from_ext = 1; ld_cnt--;
                bus.ld_we = 1'($urandom); bus.ld_addr = rand_addr(); bus.ld_wdata = $urandom;
            end else begin
                bus.ld_from_ext = 0; bus.ld_we = 0;
                if ($urandom_range(0, 49) == 0) ld_cnt = $urandom_range(1, 4);
            end
            step("rnd");
            if_hold = bus.if_req && !last_ifg;
            dm_hold = bus.dm_req && !last_dmg;
        end

        // Reset while a read is in flight.
        bus.ld_from_ext = 0; bus.ld_we = 0; bus.dm_req = 0;
        bus.if_req = 1; bus.if_addr = 16'h0008;
        repeat (3) step("mid.settle");
        bus.if_req = 0;
        rst_l = 0;
        #1;
        chk("mid.rvalid_lost", 32'({bus.if_rvalid, bus.dm_rvalid}), 32'h0);
        chk("mid.busy_load", 32'(bus.busy_load), 32'h1);
        model_reset();
        @(negedge clk);
        rst_l = 1;
        bus.ld_from_ext = 1;
        step("mid.load");
        bus.ld_from_ext = 0; bus.if_req = 1; bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 16'h0004;
        repeat (4) step("mid.run");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
